// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
   typedef enum logic {CLEAR, RUN} state_t;
   localparam int WORD_BYTES  = 8;
   localparam int BYTE_OFS_W  = 3;
   localparam int FAULT_CNT_W = 16;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core load/store bus plus valid/ready backdoor port
interface dmem_responder_if
   import dmem_pkg::*;
#(parameter int AW = 10);
   logic [63:0]            addr;
   logic                   wr_en;
   logic [63:0]            wr_data;
   logic [63:0]            rd_data;
   logic                   fault;
   logic                   mem_ready;
   logic [FAULT_CNT_W-1:0] fault_count;
   logic                   bd_valid;
   logic                   bd_ready;
   logic                   bd_we;
   logic [AW-1:0]          bd_addr;
   logic [63:0]            bd_wdata;
   logic                   bd_rvalid;
   logic [63:0]            bd_rdata;
   modport master (
      output addr, wr_en, wr_data, bd_valid, bd_we, bd_addr, bd_wdata,
      input  rd_data, fault, mem_ready, fault_count, bd_ready, bd_rvalid, bd_rdata
   );
   modport slave (
      input  addr, wr_en, wr_data, bd_valid, bd_we, bd_addr, bd_wdata,
      output rd_data, fault, mem_ready, fault_count, bd_ready, bd_rvalid, bd_rdata
   );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with one synchronous write port and two asynchronous read ports
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [63:0]   wdata_i,
   input  logic [AW-1:0] craddr_i,
   output logic [63:0]   crdata_o,
   input  logic [AW-1:0] braddr_i,
   output logic [63:0]   brdata_o
);
   logic [63:0] mem_q [DEPTH_WORDS];
   // single write port; reads see the old word until the edge
   always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
   assign crdata_o = mem_q[craddr_i];
   assign brdata_o = mem_q[braddr_i];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: self-clearing data memory serving the core and a backdoor port
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input logic               clk,
   input logic               rst,
   dmem_responder_if.slave   bus
);
   state_t                 state_q, state_d;
   logic [AW-1:0]          clear_idx_q, clear_idx_d;
   logic [FAULT_CNT_W-1:0] fault_count_q, fault_count_d;
   logic                   bd_rvalid_q, bd_rvalid_d;
   logic [63:0]            bd_rdata_q, bd_rdata_d;
   logic                   mem_ready, fault, core_we, bd_acc, we;
   logic [AW-1:0]          widx, waddr;
   logic [63:0]            wdata, core_rdata, bd_mem_rdata;
   assign mem_ready = state_q == RUN;
   assign widx      = bus.addr[AW+BYTE_OFS_W-1:BYTE_OFS_W];
   assign fault     = mem_ready & ((bus.addr[BYTE_OFS_W-1:0] != '0) | (|bus.addr[63:AW+BYTE_OFS_W]));
   assign core_we   = bus.wr_en & mem_ready & ~fault;
   assign bd_acc    = bus.bd_valid & mem_ready & ~bus.wr_en;
   // one array write per edge: clear, then core store, then backdoor store
   always_comb begin
      we    = 1'b0;
      waddr = widx;
      wdata = bus.wr_data;
      if (!rst) begin
         if (state_q == CLEAR) begin
            we    = 1'b1;
            waddr = clear_idx_q;
            wdata = '0;
         end else if (core_we) begin
            we = 1'b1;
         end else if (bd_acc && bus.bd_we) begin
            we    = 1'b1;
            waddr = bus.bd_addr;
            wdata = bus.bd_wdata;
         end
      end
   end
   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk      (clk),
      .we_i     (we),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
      .craddr_i (widx),
      .crdata_o (core_rdata),
      .braddr_i (bus.bd_addr),
      .brdata_o (bd_mem_rdata)
   );
   // next state: clear sweep, dropped-store counter, backdoor read capture
   always_comb begin
      state_d       = state_q;
      clear_idx_d   = clear_idx_q;
      fault_count_d = fault_count_q;
      bd_rvalid_d   = bd_acc & ~bus.bd_we;
      bd_rdata_d    = bd_rdata_q;
      if (state_q == CLEAR) begin
         clear_idx_d = clear_idx_q + 1'b1;
         if (clear_idx_q == AW'(DEPTH_WORDS - 1)) state_d = RUN;
      end
      if (bus.wr_en && fault && fault_count_q != '1) fault_count_d = fault_count_q + 1'b1;
      if (bd_rvalid_d) bd_rdata_d = bd_mem_rdata;
   end
   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= CLEAR;
         clear_idx_q   <= '0;
         fault_count_q <= '0;
         bd_rvalid_q   <= 1'b0;
         bd_rdata_q    <= '0;
      end else begin
         state_q       <= state_d;
         clear_idx_q   <= clear_idx_d;
         fault_count_q <= fault_count_d;
         bd_rvalid_q   <= bd_rvalid_d;
         bd_rdata_q    <= bd_rdata_d;
      end
   end
   assign bus.rd_data     = (mem_ready && !fault) ? core_rdata : '0;
   assign bus.fault       = fault;
   assign bus.mem_ready   = mem_ready;
   assign bus.fault_count = fault_count_q;
   assign bus.bd_ready    = mem_ready & ~bus.wr_en;
   assign bus.bd_rvalid   = bd_rvalid_q;
   assign bus.bd_rdata    = bd_rdata_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the single-cycle ARM core. It is the memory end of the core's Addr / WrEn_d / Db / DataInFromDMem interface.
- Serves combinational 64-bit word reads and synchronous word writes.
- Self-clears its storage after reset and holds mem_ready low until the clear completes. mem_ready is wired to hold the core in reset.
- Exposes a valid/ready backdoor port so the test harness can preload and dump memory.

Parameters:
DEPTH_WORDS, 1024, number of 64-bit words; must be a power of two, at least 2.
AW, $clog2(DEPTH_WORDS), word-index width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
addr  in  64  byte address from core (core Addr)
wr_en  in  1  core store strobe (core WrEn_d)
wr_data  in  64  core store data (core Db)
rd_data  out  64  load data to core (core DataInFromDMem)
fault  out  1  current core access is misaligned or out of range
mem_ready  out  1  clear finished; core and backdoor accesses enabled
fault_count  out  16  saturating count of dropped core writes
bd_valid  in  1  backdoor request valid
bd_ready  out  1  backdoor request accepted this cycle if bd_valid
bd_we  in  1  1 = write, 0 = read
bd_addr  in  AW  backdoor word index
bd_wdata  in  64  backdoor write data
bd_rvalid  out  1  one-cycle pulse: bd_rdata valid
bd_rdata  out  64  backdoor read data (registered)

Behaviour:
- Reset values (rst high at an edge): state=CLEAR, clear_idx=0, mem_ready=0, fault_count=0, bd_rvalid=0, bd_rdata=0.
- Reset mid-CLEAR restarts the clear from word 0. Reset mid-RUN drops mem_ready at that edge and re-clears all words.
- FSM states:
  - CLEAR: each non-reset edge writes 0 to mem[clear_idx] and increments clear_idx. The edge that writes word DEPTH_WORDS-1 moves the FSM to RUN and sets mem_ready=1. mem_ready therefore rises DEPTH_WORDS edges after the first non-reset edge.
  - RUN: holds until rst.
- Core address decode:
  - widx = addr[AW+2:3].
  - fault = mem_ready & (addr[2:0]!=0 | addr[63:AW+3]!=0). fault is combinational.
- Core read (combinational):
  - rd_data = mem[widx] when mem_ready & !fault, else 0.
  - Read-during-write to the same word returns the old value that cycle and the new value from the next edge onward.
- Core write:
  - On a posedge with wr_en & mem_ready & !fault, mem[widx] <= wr_data.
  - With wr_en & fault, the write is dropped and fault_count increments, saturating at 16'hFFFF.
  - wr_en while mem_ready=0 is ignored; no count.
- Backdoor handshake:
  - bd_ready = mem_ready & !wr_en, so core stores have priority.
  - Accept = bd_valid & bd_ready.
  - Accepted write: mem[bd_addr] <= bd_wdata at that edge.
  - Accepted read: at that edge bd_rdata <= mem[bd_addr] and bd_rvalid=1 for exactly one cycle. bd_rdata holds until the next accepted read.
  - Back-to-back accepts are allowed, one per cycle.
- Write-port arbitration at a single edge: clear > core write > backdoor write. At most one array write per edge.
- bd_valid held while bd_ready=0 must not be lost. The requester holds its fields stable until accepted.

Decomposition:
- Package dmem_pkg holds:
  - state enum {CLEAR, RUN};
  - WORD_BYTES=8;
  - BYTE_OFS_W=3;
  - FAULT_CNT_W=16.
- Sub-module dmem_array: DEPTH_WORDS x 64 storage with one synchronous write port (we, waddr, wdata) and two asynchronous read ports (core, backdoor).
- dmem_responder contains the FSM, clear counter, decode/fault logic, write mux, handshake and counters.

Test Plan:
1. DEPTH_WORDS=16; rst high for 2 edges, then low -> mem_ready=0 for 15 edges, 1 after the 16th; bd reads of words 0..15 all return 0.
2. Core wr_en=1, addr=0x18, wr_data=0xDEADBEEF_CAFEF00D -> same cycle rd_data=0; after the edge, wr_en=0, rd_data=0xDEADBEEF_CAFEF00D; bd read of word 3 returns the same value.
3. Core wr_en=1, addr=0x1C -> fault=1, no write, fault_count=1; addr=0x80 with wr_en -> fault=1, rd_data=0, fault_count=2; 70000 faulting writes -> fault_count=0xFFFF.
4. Backdoor write word 5 = 0x1234 accepted -> next cycle core addr=0x28 gives rd_data=0x1234; backdoor read word 5 -> bd_rvalid high exactly one cycle after accept, bd_rdata=0x1234.
5. bd_valid=1 with wr_en=1 for 3 cycles -> bd_ready=0 for those cycles, no backdoor effect; accepted on the first cycle with wr_en=0.
6. Reset asserted in RUN after writes -> mem_ready=0 at that edge; after 16 clear edges all words read 0 and fault_count=0.
